// File: rtl/expansion_shiftreg_pkg.sv
// Shared definitions for the expansion shift-register link (target RTL and initiator bench model).
package expansion_shiftreg_pkg;

  typedef enum logic [1:0] {
    LOADING    = 2'd0,
    WAIT_FIRST = 2'd1,
    SHIFTING   = 2'd2
  } link_state_e;

  // Synchronised view of one link pin: level plus single-clk edge pulses.
  typedef struct packed {
    logic lvl;
    logic rise;
    logic fall;
  } pin_evt_t;

  localparam pin_evt_t PIN_EVT_IDLE = '{lvl: 1'b1, rise: 1'b0, fall: 1'b0};

  localparam int          DEF_WIDTH      = 8;
  localparam logic [31:0] DEF_SAFE_VALUE = 32'h0;

  localparam int NUM_PINS = 3;
  localparam int PIN_SCK  = 0;
  localparam int PIN_LD   = 1;
  localparam int PIN_SDO  = 2;

endpackage

// File: rtl/expansion_shiftreg_target_pin_sync.sv
// N-flop synchroniser for one async link pin with registered rise/fall pulses.
module shiftreg_pin_sync
  import expansion_shiftreg_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     pin,
  output pin_evt_t evt
);

  logic [STAGES-1:0] sync_pipe;

  // Flops idle high so a released reset with pins high produces no edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_pipe <= '1;
      evt       <= PIN_EVT_IDLE;
    end else begin
      sync_pipe <= {sync_pipe[STAGES-2:0], pin};
      evt.lvl   <= sync_pipe[STAGES-1];
      evt.rise  <= sync_pipe[STAGES-1] & ~evt.lvl;
      evt.fall  <= ~sync_pipe[STAGES-1] & evt.lvl;
    end
  end

endmodule

// File: rtl/expansion_shiftreg_target.sv
// Far end of the expansion shift-register link: fabric emulation of a 74HC595 + 74HC165 pair,
// with frame checking and a link watchdog.
module expansion_shiftreg_target
  import expansion_shiftreg_pkg::*;
#(
  parameter int               WIDTH       = DEF_WIDTH,
  parameter int               SYNC_STAGES = 2,
  parameter int               TIMEOUT     = 5000000,
  parameter logic [WIDTH-1:0] SAFE_VALUE  = DEF_SAFE_VALUE[WIDTH-1:0]
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             SHIFT_CLK,
  input  logic             SHIFT_LOAD,
  input  logic             SHIFT_OUT,
  output logic             SHIFT_IN,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             frame_valid,
  output logic             frame_error,
  output logic             link_timeout
);

  localparam int CNT_W = $clog2(WIDTH + 2);
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WIDTH + 1);
  localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TIMEOUT);

  logic [NUM_PINS-1:0] pins;
  pin_evt_t [NUM_PINS-1:0] evt;

  assign pins[PIN_SCK] = SHIFT_CLK;
  assign pins[PIN_LD]  = SHIFT_LOAD;
  assign pins[PIN_SDO] = SHIFT_OUT;

  for (genvar g = 0; g < NUM_PINS; g++) begin : g_sync
    shiftreg_pin_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .pin  (pins[g]),
      .evt  (evt[g])
    );
  end

  logic sck_rise, sck_fall, ld_rise, ld_fall, sdo_lvl;
  assign sck_rise = evt[PIN_SCK].rise;
  assign sck_fall = evt[PIN_SCK].fall;
  assign ld_rise  = evt[PIN_LD].rise;
  assign ld_fall  = evt[PIN_LD].fall;
  assign sdo_lvl  = evt[PIN_SDO].lvl;

  logic unused_evt;
  assign unused_evt = ^{evt[PIN_SDO].rise, evt[PIN_SDO].fall, evt[PIN_SCK].lvl, evt[PIN_LD].lvl};

  link_state_e      state;
  logic [WIDTH-1:0] rx_sr, tx_sr, tx_shl;
  logic [CNT_W-1:0] bit_cnt;
  logic [WD_W-1:0]  wdog;
  logic             frame_ok;

  assign tx_shl   = tx_sr << 1;
  assign frame_ok = (state == SHIFTING) && (bit_cnt == CNT_FULL);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= LOADING;
      rx_sr        <= '0;
      tx_sr        <= '0;
      bit_cnt      <= '0;
      wdog         <= '0;
      data_out     <= SAFE_VALUE;
      SHIFT_IN     <= 1'b0;
      frame_valid  <= 1'b0;
      frame_error  <= 1'b0;
      link_timeout <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      frame_error <= 1'b0;

      // Watchdog forces the safe word exactly once, on the cycle it expires.
      if (wdog != WD_MAX) begin
        wdog <= wdog + 1'b1;
        if (wdog == WD_MAX - 1'b1) begin
          link_timeout <= 1'b1;
          data_out     <= SAFE_VALUE;
        end
      end

      if (ld_fall) begin
        state <= LOADING;
        if (frame_ok) begin
          data_out     <= rx_sr;
          frame_valid  <= 1'b1;
          wdog         <= '0;
          link_timeout <= 1'b0;
        end else if (bit_cnt != '0 || state == SHIFTING) begin
          frame_error <= 1'b1;
        end
      end else begin
        case (state)
          LOADING: begin
            tx_sr    <= data_in;
            SHIFT_IN <= data_in[WIDTH-1];
            bit_cnt  <= '0;
            if (ld_rise) state <= WAIT_FIRST;
          end
          // First falling edge carries stale data from before the load.
          WAIT_FIRST: if (sck_fall) state <= SHIFTING;
          SHIFTING: begin
            if (sck_fall) begin
              rx_sr <= (rx_sr << 1) | WIDTH'(sdo_lvl);
              if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + 1'b1;
            end
            if (sck_rise) begin
              tx_sr    <= tx_shl;
              SHIFT_IN <= tx_shl[WIDTH-1];
            end
          end
          default: state <= LOADING;
        endcase
      end
    end
  end

endmodule
